// File: rtl/watch_pkg.sv
// Shared constants and helpers for the watch scan/calibration front end.
package watch_pkg;

  // Calibration mode codes as seen on control_dig
  typedef enum logic [2:0] {
    MODE_RUN   = 3'd0,
    MODE_MIN_L = 3'd1,
    MODE_MIN_H = 3'd2,
    MODE_HR_L  = 3'd3,
    MODE_HR_H  = 3'd4
  } mode_t;

  // Display slot codes as seen on sel
  localparam logic [1:0] SLOT_HR_H  = 2'd0;
  localparam logic [1:0] SLOT_HR_L  = 2'd1;
  localparam logic [1:0] SLOT_MIN_H = 2'd2;
  localparam logic [1:0] SLOT_MIN_L = 2'd3;

  // Mode button cycles run -> hr_h -> hr_l -> min_h -> min_l -> run
  function automatic mode_t mode_advance(input mode_t m);
    mode_t r;
    case (m)
      MODE_RUN:   r = MODE_HR_H;
      MODE_HR_H:  r = MODE_HR_L;
      MODE_HR_L:  r = MODE_MIN_H;
      MODE_MIN_H: r = MODE_MIN_L;
      default:    r = MODE_RUN;
    endcase
    return r;
  endfunction

  // Counter width for a divisor, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/watch_scan_ctrl_key_debounce.sv
// One push-button conditioner: 2-FF synchroniser, debounce counter and a
// registered one-cycle pulse on each accepted press (stable 1 -> 0).
module key_debounce #(
  parameter int DEB_CNT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  import watch_pkg::*;

  localparam int             CW       = cnt_width(DEB_CNT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CNT - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          mismatch;
  logic          at_last;

  assign mismatch = (sync_p1 != stable);
  assign at_last  = (cnt == CNT_LAST);

  // Bring the raw asynchronous level into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level after DEB_CNT mismatched cycles; pulse on press only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b1;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (mismatch) begin
        if (at_last) begin
          stable <= sync_p1;
          cnt    <= '0;
          // new level is ~stable, so a 1 -> 0 step is exactly stable == 1
          press  <= stable;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/watch_scan_ctrl.sv
// Watch display front end: digit scan multiplexer, calibration mode FSM,
// increment requests and blink enable for the digit under adjustment.
module watch_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000,
  parameter int DEB_CNT   = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic [3:0] hr_h,
  input  logic [3:0] hr_l,
  input  logic [3:0] min_h,
  input  logic [3:0] min_l,
  output logic [1:0] sel,
  output logic [3:0] key,
  output logic [2:0] control_dig,
  output logic       sec_en,
  output logic       adj_inc
);
  import watch_pkg::*;

  localparam int                SCAN_W     = cnt_width(SCAN_DIV);
  localparam int                BLINK_W    = cnt_width(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic               scan_wrap;
  logic [1:0]         sel_nxt;
  logic [3:0]         digit_nxt;
  logic               mode_press;
  logic               inc_press;
  mode_t              mode;
  mode_t              mode_nxt;
  logic               inc_req;
  logic               user_act;
  logic [BLINK_W-1:0] blink_cnt;

  assign scan_wrap = (scan_cnt == SCAN_LAST);
  assign sel_nxt   = sel + 2'd1;

  // Pick the digit for the slot that becomes active on the next wrap
  always_comb begin
    digit_nxt = hr_h;
    case (sel_nxt)
      SLOT_HR_H:  digit_nxt = hr_h;
      SLOT_HR_L:  digit_nxt = hr_l;
      SLOT_MIN_H: digit_nxt = min_h;
      default:    digit_nxt = min_l;
    endcase
  end

  // Scan counter; sel and key move together so key always matches sel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      sel      <= SLOT_HR_H;
      key      <= 4'd0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      sel      <= sel_nxt;
      key      <= digit_nxt;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_mode (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_mode_n),
    .press (mode_press)
  );

  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_inc (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_inc_n),
    .press (inc_press)
  );

  // Mode state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode <= MODE_RUN;
    else     mode <= mode_nxt;
  end

  // Next mode; a mode press wins over a coincident inc press
  always_comb begin
    mode_nxt = mode;
    inc_req  = 1'b0;
    if (mode_press) begin
      mode_nxt = mode_advance(mode);
    end else if (inc_press && (mode != MODE_RUN)) begin
      inc_req = 1'b1;
    end
  end

  // Mode code straight out of the state register
  always_comb begin
    control_dig = mode;
  end

  // One-cycle increment request, one edge after the press pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) adj_inc <= 1'b0;
    else     adj_inc <= inc_req;
  end

  assign user_act = mode_press | inc_req;

  // Blink: restart visible on user action, idle in run mode, else toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      sec_en    <= 1'b1;
    end else if (user_act || (mode == MODE_RUN)) begin
      blink_cnt <= '0;
      sec_en    <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      sec_en    <= ~sec_en;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

endmodule

// File: tb/tb_watch_scan_ctrl.sv
// Self-checking bench for watch_scan_ctrl with small divisors.
module tb_watch_scan_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 6;
  localparam int DEB_CNT   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_mode_n;
  logic       key_inc_n;
  logic [3:0] hr_h, hr_l, min_h, min_l;
  logic [1:0] sel;
  logic [3:0] key;
  logic [2:0] control_dig;
  logic       sec_en;
  logic       adj_inc;

  watch_scan_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV),
    .DEB_CNT   (DEB_CNT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_mode_n  (key_mode_n),
    .key_inc_n   (key_inc_n),
    .hr_h        (hr_h),
    .hr_l        (hr_l),
    .min_h       (min_h),
    .min_l       (min_l),
    .sel         (sel),
    .key         (key),
    .control_dig (control_dig),
    .sec_en      (sec_en),
    .adj_inc     (adj_inc)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int inc_cnt = 0;
  int chg_cyc = 0;
  int last_cyc = 0;
  bit have_last = 0;
  logic [2:0] prev_cd = 3'd0;
  logic [1:0] prev_sel = 2'd0;
  logic [2:0] mode_q[$];
  logic [3:0] dig [4];

  typedef struct {
    bit         m;
    bit         i;
    int         hold;
    logic [2:0] exp_mode;
    int         exp_inc;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: mode scoreboard, inc counting and scan checking
  always @(negedge clk) begin
    if (rst) begin
      prev_cd   = control_dig;
      prev_sel  = sel;
      have_last = 0;
    end else begin
      if (adj_inc) inc_cnt++;
      if (control_dig != prev_cd) begin
        chg_cyc = cyc;
        if (mode_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_mode_change: actual %0d required %0d", control_dig, prev_cd);
        end else begin
          check("mode_scoreboard", int'(control_dig), int'(mode_q.pop_front()));
        end
        prev_cd = control_dig;
      end
      if (sel != prev_sel) begin
        check("scan_sel", int'(sel), int'(2'(prev_sel + 2'd1)));
        check("scan_key", int'(key), int'(dig[sel]));
        if (have_last) check("scan_period", cyc - last_cyc, SCAN_DIV);
        have_last = 1;
        last_cyc  = cyc;
        prev_sel  = sel;
      end
    end
  end

  task automatic press(input bit m, input bit i, input int hold, input int settle);
    key_mode_n = !m;
    key_inc_n  = !i;
    repeat (hold) @(negedge clk);
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    repeat (settle) @(negedge clk);
  endtask

  task automatic step_mode(input logic [2:0] exp);
    mode_q.push_back(exp);
    press(1'b1, 1'b0, 20, 25);
    check("step_mode", int'(control_dig), int'(exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},  int'(sel), 0);
    check({tag, "_key"},  int'(key), 0);
    check({tag, "_mode"}, int'(control_dig), 0);
    check({tag, "_sec"},  int'(sec_en), 1);
    check({tag, "_inc"},  int'(adj_inc), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int inc0, start, t;
    logic [2:0] cur;
    logic prevs;
    bit bad;

    dig[0] = 4'd1; dig[1] = 4'd2; dig[2] = 4'd3; dig[3] = 4'd4;
    hr_h = 4'd1; hr_l = 4'd2; min_h = 4'd3; min_l = 4'd4;
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    rst = 1'b0;

    vecs[0] = '{1'b1, 1'b0,  5, 3'd0, 0};
    vecs[1] = '{1'b1, 1'b0, 20, 3'd4, 0};
    vecs[2] = '{1'b0, 1'b1, 20, 3'd4, 1};
    vecs[3] = '{1'b1, 1'b0, 20, 3'd3, 0};
    vecs[4] = '{1'b1, 1'b0, 20, 3'd2, 0};
    vecs[5] = '{1'b1, 1'b0, 20, 3'd1, 0};
    vecs[6] = '{1'b1, 1'b0, 20, 3'd0, 0};
    vecs[7] = '{1'b0, 1'b1, 20, 3'd0, 0};
    vecs[8] = '{1'b1, 1'b0, 20, 3'd4, 0};
    vecs[9] = '{1'b1, 1'b1, 20, 3'd3, 0};

    // asynchronous reset, before any clock edge
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (24) @(negedge clk);

    // table-driven button vectors
    cur = 3'd0;
    for (int k = 0; k < 10; k++) begin
      inc0    = inc_cnt;
      start   = cyc;
      chg_cyc = 0;
      if (vecs[k].exp_mode != cur) mode_q.push_back(vecs[k].exp_mode);
      press(vecs[k].m, vecs[k].i, vecs[k].hold, 25);
      check($sformatf("vec%0d_mode", k), int'(control_dig), int'(vecs[k].exp_mode));
      check($sformatf("vec%0d_inc", k), inc_cnt - inc0, vecs[k].exp_inc);
      if (vecs[k].exp_mode != cur)
        check($sformatf("vec%0d_latency_le12", k),
              int'((chg_cyc - start >= 1) && (chg_cyc - start <= 12)), 1);
      cur = vecs[k].exp_mode;
    end

    // increment in mode 4 while the digit is blanked
    step_mode(3'd2);
    step_mode(3'd1);
    step_mode(3'd0);
    step_mode(3'd4);
    t = 0;
    prevs = sec_en;
    while (!(prevs == 1'b1 && sec_en == 1'b0) && t < 40) begin
      prevs = sec_en;
      @(negedge clk);
      t++;
    end
    check("blank_found", int'(t < 40), 1);
    repeat (4) @(negedge clk);
    inc0 = inc_cnt;
    key_inc_n = 1'b0;
    t = 0;
    prevs = sec_en;
    while (!adj_inc && t < 40) begin
      prevs = sec_en;
      @(negedge clk);
      t++;
    end
    check("inc_seen", int'(t < 40), 1);
    check("inc_sec_before", int'(prevs), 0);
    check("inc_sec_at", int'(sec_en), 1);
    @(negedge clk);
    check("inc_one_cycle", int'(adj_inc), 0);
    key_inc_n = 1'b1;
    repeat (25) @(negedge clk);
    check("inc_count", inc_cnt - inc0, 1);

    // blink pattern right after entering mode 3
    mode_q.push_back(3'd3);
    key_mode_n = 1'b0;
    t = 0;
    while (control_dig != 3'd3 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("blink_mode_entered", int'(t < 40), 1);
    bad = 0;
    for (int i = 0; i < 18; i++) begin
      if (sec_en !== ((i < 6 || i >= 12) ? 1'b1 : 1'b0)) begin
        if (!bad) $display("FAIL blink_sample%0d: actual %0d required %0d", i, sec_en,
                           (i < 6 || i >= 12) ? 1 : 0);
        bad = 1;
      end
      @(negedge clk);
    end
    check("blink_pattern_ok", int'(bad), 0);
    key_mode_n = 1'b1;
    repeat (25) @(negedge clk);

    // back to run: sec_en constant 1
    step_mode(3'd2);
    step_mode(3'd1);
    step_mode(3'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (sec_en !== 1'b1) bad = 1;
      @(negedge clk);
    end
    check("run_sec_const", int'(bad), 0);

    // reset in the middle of calibration with inc held
    step_mode(3'd4);
    step_mode(3'd3);
    step_mode(3'd2);
    key_inc_n = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    inc0 = inc_cnt;
    repeat (30) @(negedge clk);
    key_inc_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_inc_none", inc_cnt - inc0, 0);
    check("midrst_mode", int'(control_dig), 0);

    check("scoreboard_drained", mode_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/watch_scan_ctrl.md
Name: watch_scan_ctrl

Overview:
Front end of the watch display path. Time-multiplexes the four BCD time digits onto the digit-select/value interface consumed by the seven-segment driver. Generates the calibration mode code and the blink enable from two debounced push buttons. Issues one-cycle increment requests to the time counter for the digit under calibration.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (1 ms at 50 MHz)
BLINK_DIV, 12500000, clk cycles per blink half-period (2 Hz blink at 50 MHz)
DEB_CNT, 1000000, consecutive stable cycles needed to accept a button level (20 ms)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
key_mode_n  in  1  raw mode button, active-low, asynchronous to clk
key_inc_n  in  1  raw increment button, active-low, asynchronous to clk
hr_h  in  4  BCD hour tens
hr_l  in  4  BCD hour units
min_h  in  4  BCD minute tens
min_l  in  4  BCD minute units
sel  out  2  digit slot: 0=hr_h, 1=hr_l, 2=min_h, 3=min_l
key  out  4  BCD value of the digit in slot sel
control_dig  out  3  mode: 0 run, 4 hr_h adj, 3 hr_l adj, 2 min_h adj, 1 min_l adj
sec_en  out  1  blink enable; 1 = adjusted digit visible
adj_inc  out  1  one-cycle increment request for the digit selected by control_dig

Behaviour:
- Reset values (asynchronous assertion): sel=0, key=0, control_dig=0, sec_en=1, adj_inc=0. All counters cleared. Debounced button states = released (1).
- Scan: a free-running counter from 0 to SCAN_DIV-1. On wrap, sel increments modulo 4 (3 wraps to 0).
- key is registered and updates on the same edge as sel, so key always matches sel. Digit inputs are sampled at that edge; no input range check is performed.
- Button conditioning, per button:
  - 2-FF synchroniser.
  - Debounce counter increments while the synchronised level differs from the stable level and clears when they match.
  - When the counter reaches DEB_CNT-1 while still mismatched, the stable level takes the new value and the counter clears.
  - A press pulse is one cycle, registered, on each stable 1->0 transition. Releases produce nothing.
- Mode FSM on control_dig, advancing on each mode press: 0 -> 4 -> 3 -> 2 -> 1 -> 0. No other transitions.
- Increment: an inc press in modes 1-4 produces adj_inc=1 for exactly one cycle, on the edge after the press pulse. An inc press in mode 0 is discarded.
- Simultaneous mode and inc press pulses in the same cycle: the mode advance wins and the inc press is dropped.
- Blink, with control_dig=0: sec_en is held at 1 and the blink counter is held at 0.
- Blink, with control_dig!=0: sec_en toggles each time the blink counter reaches BLINK_DIV-1.
- On any mode change or any adj_inc, the blink counter clears and sec_en is forced to 1, so the digit is visible immediately after a user action.
- Counter widths are $clog2 of each divisor, minimum 1 bit. All comparisons use the full counter width.
- Latency from a clean raw press to control_dig change is 2 + DEB_CNT + 2 cycles, ±1.
- Reset asserted mid-press or mid-calibration returns the block to mode 0. A press still held after reset release is accepted once, after the debounce time.

Decomposition:
- Package watch_pkg holds:
  - mode constants MODE_RUN=3'd0, MODE_MIN_L=3'd1, MODE_MIN_H=3'd2, MODE_HR_L=3'd3, MODE_HR_H=3'd4
  - slot constants SLOT_HR_H..SLOT_MIN_L = 2'd0..2'd3
  - the mode-advance function
- Sub-module key_debounce: synchroniser, debounce counter and press pulse, parameterised by DEB_CNT. It is instantiated twice. Scan, mode FSM and blink logic stay in the top module.

Test Plan:
- Reset: assert rst with no clock edge -> sel=0, key=0, control_dig=0, sec_en=1, adj_inc=0 immediately.
- Scan: SCAN_DIV=4, hr_h=1, hr_l=2, min_h=3, min_l=4 -> sel steps 0,1,2,3,0 every 4 cycles, with key=1,2,3,4,1 on the same edges.
- Debounce: DEB_CNT=8.
  - key_mode_n low for 5 cycles -> control_dig stays 0.
  - Held low for 20 cycles -> control_dig becomes 4 exactly once within 12 cycles.
  - Four further clean presses -> 3, 2, 1, 0.
- Increment:
  - Mode 0, press inc -> adj_inc never asserts.
  - Mode 4 with sec_en currently 0, press inc -> exactly one adj_inc cycle, and sec_en=1 on that same edge.
  - Simultaneous mode+inc pulses -> mode advances to 3 and no adj_inc.
- Blink: BLINK_DIV=6, mode 3 -> sec_en pattern 1×6, 0×6, 1×6. Return to mode 0 -> sec_en=1 constant.
- Reset mid-operation: mode 2 with key_inc_n held low, then pulse rst -> outputs return to reset values. After release, one adj_inc is suppressed (mode 0) and control_dig stays 0.
